// File: rtl/exe_stage_red.sv
// exe_stage_red -- reduced scalar execute stage (register-read -> write-back).
//
// Purpose:
//   Executes ALU add/sub and JAL/JALR resolution with zero latency on the arith
//   channel. Optionally executes a pipelined 64-bit multiply and an iterative
//   signed divide on the mul_div channel. A structural stall holds
//   register-read off while a long-latency unit is busy.
//
// Build option:
//   EXE_MULDIV_EN -- when defined, the multiplier and divider are built.
//                    When undefined, unit 1/2 issues raise illegal_o and the
//                    mul_div channel and stall_o stay low.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   kill_i                  flush: drops in-flight mul/div, masks valids
//   valid_i, unit_i, op_i   instruction present, unit select, sub-op
//   use_imm_i               ALU operand2 = imm_i
//   pc_i, imm_i, rs1_i, rs2_i, rdy1_i, rdy2_i, pred_addr_i   operands
//   arith_valid_o, arith_result_o, arith_result_pc_o, correct_branch_pred_o
//   mul_div_valid_o, mul_div_result_o
//   stall_o                 structural stall to register-read
//   illegal_o               unsupported unit issued
module exe_stage_red #(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            valid_i,
  input  logic [1:0]      unit_i,
  input  logic            op_i,
  input  logic            use_imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            rdy1_i,
  input  logic            rdy2_i,
  input  logic [XLEN-1:0] pred_addr_i,
  output logic            arith_valid_o,
  output logic [XLEN-1:0] arith_result_o,
  output logic [XLEN-1:0] arith_result_pc_o,
  output logic            mul_div_valid_o,
  output logic [XLEN-1:0] mul_div_result_o,
  output logic            stall_o,
  output logic            correct_branch_pred_o,
  output logic            illegal_o
);

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;
  localparam logic [1:0] UNIT_BR  = 2'd3;

  // stall_o comes only from registers, so issue has no combinational loop.
  logic issue;
  assign issue = valid_i & rdy1_i & rdy2_i & ~stall_o & ~kill_i;

  // ---------------- ALU / branch: purely combinational ----------------
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;

  assign op2         = use_imm_i ? imm_i : rs2_i;
  assign link_addr   = pc_i + XLEN'(4);
  assign jalr_sum    = rs1_i + imm_i;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    arith_result_o        = '0;
    arith_result_pc_o     = '0;
    correct_branch_pred_o = 1'b1;
    case (unit_i)
      UNIT_ALU: arith_result_o = op_i ? (rs1_i - op2) : (rs1_i + op2);
      UNIT_BR: begin
        arith_result_o = link_addr;
        if (op_i) begin
          arith_result_pc_o     = jalr_target;
          correct_branch_pred_o = (pred_addr_i == jalr_target);
        end
      end
      default: ;
    endcase
  end

  assign arith_valid_o = issue & ((unit_i == UNIT_ALU) | (unit_i == UNIT_BR));

`ifdef EXE_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN);

  logic mul_issue;
  logic div_issue;
  assign mul_issue = issue & (unit_i == UNIT_MUL);
  assign div_issue = issue & (unit_i == UNIT_DIV);
  assign illegal_o = 1'b0;

  // ---------------- multiplier: MUL_LAT-deep register pipeline ----------------
  logic [MUL_LAT-1:0] mul_v_reg;
  logic [XLEN-1:0]    mul_p_reg [MUL_LAT];
  logic [XLEN-1:0]    mul_prod;

  assign mul_prod = rs1_i * rs2_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mul_v_reg <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_p_reg[i] <= '0;
    end else begin
      mul_v_reg[0] <= mul_issue;
      if (mul_issue) mul_p_reg[0] <= mul_prod;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_v_reg[i] <= mul_v_reg[i-1] & ~kill_i;
        mul_p_reg[i] <= mul_p_reg[i-1];
      end
    end
  end

  // ---------------- divider: restoring radix-2 on magnitudes ----------------
  typedef enum logic [1:0] {DIV_IDLE, DIV_ITER, DIV_FIX} div_state_t;

  div_state_t      div_state_reg, div_state_next;
  logic [XLEN-1:0] div_r_reg, div_q_reg, div_d_reg, div_res_reg;
  logic [CNT_W-1:0] div_cnt_reg;
  logic            div_neg_reg;
  logic            div_v_reg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic [2*XLEN-1:0] first_step, next_step;

  // Magnitude of -2^(XLEN-1) is representable as an unsigned value, so the
  // overflow case falls out of the normal iteration and sign fix.
  assign rs1_mag = rs1_i[XLEN-1] ? -rs1_i : rs1_i;
  assign rs2_mag = rs2_i[XLEN-1] ? -rs2_i : rs2_i;

  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] d);
    logic [XLEN:0] trial;
    trial = {r, q[XLEN-1]} - {1'b0, d};
    if (trial[XLEN]) div_step = {r[XLEN-2:0], q[XLEN-1], q[XLEN-2:0], 1'b0};
    else             div_step = {trial[XLEN-1:0], q[XLEN-2:0], 1'b1};
  endfunction

  // The issue edge already performs the first iteration so that 64 iterations
  // plus the sign-fix edge put the result exactly 65 cycles after issue.
  assign first_step = div_step('0, rs1_mag, rs2_mag);
  assign next_step  = div_step(div_r_reg, div_q_reg, div_d_reg);

  always_comb begin
    div_state_next = div_state_reg;
    if (kill_i) begin
      div_state_next = DIV_IDLE;
    end else begin
      case (div_state_reg)
        DIV_IDLE: if (div_issue && rs2_i != '0) div_state_next = DIV_ITER;
        DIV_ITER: if (div_cnt_reg == CNT_W'(1)) div_state_next = DIV_FIX;
        DIV_FIX:  div_state_next = DIV_IDLE;
        default:  div_state_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) div_state_reg <= DIV_IDLE;
    else       div_state_reg <= div_state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_r_reg   <= '0;
      div_q_reg   <= '0;
      div_d_reg   <= '0;
      div_res_reg <= '0;
      div_cnt_reg <= '0;
      div_neg_reg <= 1'b0;
      div_v_reg   <= 1'b0;
    end else if (kill_i) begin
      div_v_reg <= 1'b0;
    end else begin
      div_v_reg <= 1'b0;
      if (div_issue) begin
        if (rs2_i == '0) begin
          // Divide by zero short-circuits to all-ones in one cycle.
          div_v_reg   <= 1'b1;
          div_res_reg <= '1;
        end else begin
          {div_r_reg, div_q_reg} <= first_step;
          div_d_reg   <= rs2_mag;
          div_neg_reg <= rs1_i[XLEN-1] ^ rs2_i[XLEN-1];
          div_cnt_reg <= CNT_W'(XLEN - 1);
        end
      end
      case (div_state_reg)
        DIV_ITER: begin
          {div_r_reg, div_q_reg} <= next_step;
          div_cnt_reg <= div_cnt_reg - CNT_W'(1);
        end
        DIV_FIX: begin
          div_v_reg   <= 1'b1;
          div_res_reg <= div_neg_reg ? -div_q_reg : div_q_reg;
        end
        default: ;
      endcase
    end
  end

  assign stall_o          = (|mul_v_reg) | (div_state_reg != DIV_IDLE) | div_v_reg;
  assign mul_div_valid_o  = (mul_v_reg[MUL_LAT-1] | div_v_reg) & ~kill_i;
  assign mul_div_result_o = mul_v_reg[MUL_LAT-1] ? mul_p_reg[MUL_LAT-1] :
                            (div_v_reg ? div_res_reg : '0);
`else
  // No long-latency units: the mul_div valid is a registered constant zero so
  // the output keeps registered reset behaviour.
  logic md_valid_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) md_valid_reg <= 1'b0;
    else       md_valid_reg <= 1'b0;
  end

  assign illegal_o        = issue & ((unit_i == UNIT_MUL) | (unit_i == UNIT_DIV));
  assign stall_o          = 1'b0;
  assign mul_div_valid_o  = md_valid_reg;
  assign mul_div_result_o = '0;
`endif

endmodule

// File: tb/tb_exe_stage_red.sv
module tb_exe_stage_red;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill_i, valid_i, op_i, use_imm_i, rdy1_i, rdy2_i;
  logic [1:0]  unit_i;
  logic [63:0] pc_i, imm_i, rs1_i, rs2_i, pred_addr_i;
  logic        arith_valid_o, mul_div_valid_o, stall_o, correct_branch_pred_o, illegal_o;
  logic [63:0] arith_result_o, arith_result_pc_o, mul_div_result_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_stage_red #(.XLEN(64), .MUL_LAT(2)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .kill_i                (kill_i),
    .valid_i               (valid_i),
    .unit_i                (unit_i),
    .op_i                  (op_i),
    .use_imm_i             (use_imm_i),
    .pc_i                  (pc_i),
    .imm_i                 (imm_i),
    .rs1_i                 (rs1_i),
    .rs2_i                 (rs2_i),
    .rdy1_i                (rdy1_i),
    .rdy2_i                (rdy2_i),
    .pred_addr_i           (pred_addr_i),
    .arith_valid_o         (arith_valid_o),
    .arith_result_o        (arith_result_o),
    .arith_result_pc_o     (arith_result_pc_o),
    .mul_div_valid_o       (mul_div_valid_o),
    .mul_div_result_o      (mul_div_result_o),
    .stall_o               (stall_o),
    .correct_branch_pred_o (correct_branch_pred_o),
    .illegal_o             (illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction mid-cycle (after the falling edge).
  task automatic drive(input logic [1:0] u, input logic o, input logic ui,
                       input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pred);
    @(negedge clk);
    unit_i = u; op_i = o; use_imm_i = ui; pc_i = pc; imm_i = imm;
    rs1_i = a; rs2_i = b; pred_addr_i = pred;
    rdy1_i = 1'b1; rdy2_i = 1'b1; valid_i = 1'b1;
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [1:0] u, input logic o,
                         input logic ui, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] pred,
                         input logic [63:0] exp_r, input logic [63:0] exp_pc,
                         input logic exp_c);
    drive(u, o, ui, pc, imm, a, b, pred);
    chk({tag, "_valid"}, 64'(arith_valid_o), 64'd1);
    chk({tag, "_result"}, arith_result_o, exp_r);
    chk({tag, "_pc"}, arith_result_pc_o, exp_pc);
    chk({tag, "_pred"}, 64'(correct_branch_pred_o), 64'(exp_c));
    chk({tag, "_illegal"}, 64'(illegal_o), 64'd0);
    $display("%s: unit=%0d op=%0d rs1=%h rs2=%h imm=%h -> %h pc=%h", tag, u, o, a, b, imm,
             arith_result_o, arith_result_pc_o);
    valid_i = 1'b0;
  endtask

`ifdef EXE_MULDIV_EN
  // Issue a MUL/DIV and check result timing, value and stall coverage.
  task automatic md_vec(input string tag, input logic [1:0] u, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int stall_miss = 0;
    int early = 0;
    drive(u, 1'b0, 1'b0, 64'd0, 64'd0, a, b, 64'd0);
    chk({tag, "_illegal"}, 64'(illegal_o), 64'd0);
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      if (!stall_o) stall_miss++;
      if (mul_div_valid_o) early++;
    end
    @(negedge clk);
    chk({tag, "_stall_hold"}, 64'(stall_miss), 64'd0);
    chk({tag, "_early_valid"}, 64'(early), 64'd0);
    chk({tag, "_valid"}, 64'(mul_div_valid_o), 64'd1);
    chk({tag, "_result"}, mul_div_result_o, exp);
    chk({tag, "_stall_at_result"}, 64'(stall_o), 64'd1);
    $display("%s: rs1=%h rs2=%h -> %h after %0d cycles", tag, a, b, mul_div_result_o, lat);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 64'(mul_div_valid_o), 64'd0);
    chk({tag, "_stall_release"}, 64'(stall_o), 64'd0);
  endtask
`endif

  initial begin
    logic [63:0] a, b, e;
    int cnt;

    rst = 1'b1; kill_i = 1'b0; valid_i = 1'b0; op_i = 1'b0; use_imm_i = 1'b0;
    unit_i = 2'd0; rdy1_i = 1'b0; rdy2_i = 1'b0;
    pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; pred_addr_i = '0;

    #2;
    chk("reset_stall", 64'(stall_o), 64'd0);
    chk("reset_md_valid", 64'(mul_div_valid_o), 64'd0);
    chk("reset_md_result", mul_div_result_o, 64'd0);
    chk("reset_arith_valid", 64'(arith_valid_o), 64'd0);
    $display("reset: stall=%0d md_valid=%0d", stall_o, mul_div_valid_o);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ALU and branch directed vectors
    alu_vec("add_wrap", 2'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
            64'd0, 64'd0, 1'b1);
    alu_vec("sub_neg", 2'd0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd5, 64'd7, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1);
    alu_vec("add_imm", 2'd0, 1'b0, 1'b1, 64'd0, 64'd3, 64'd10, 64'd999, 64'd0,
            64'd13, 64'd0, 1'b1);
    alu_vec("sub_imm", 2'd0, 1'b1, 1'b1, 64'd0, 64'd3, 64'd10, 64'd999, 64'd0,
            64'd7, 64'd0, 1'b1);
    alu_vec("jal", 2'd3, 1'b0, 1'b0, 64'h1000, 64'd0, 64'd0, 64'd0, 64'd0,
            64'h1004, 64'd0, 1'b1);
    alu_vec("jalr_hit", 2'd3, 1'b1, 1'b0, 64'h3000, 64'd4, 64'h2001, 64'd0, 64'h2004,
            64'h3004, 64'h2004, 1'b1);
    alu_vec("jalr_miss", 2'd3, 1'b1, 1'b0, 64'h3000, 64'd4, 64'h2001, 64'd0, 64'h2000,
            64'h3004, 64'h2004, 1'b0);

    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      e = a + b;
      alu_vec("add_rand", 2'd0, 1'b0, 1'b0, 64'd0, 64'd0, a, b, 64'd0, e, 64'd0, 1'b1);
    end

    // Issue gating: kill and operand-not-ready both block arith_valid_o
    drive(2'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd1, 64'd2, 64'd0);
    kill_i = 1'b1;
    #1 chk("kill_masks_arith", 64'(arith_valid_o), 64'd0);
    kill_i = 1'b0;
    rdy2_i = 1'b0;
    #1 chk("rdy2_blocks_arith", 64'(arith_valid_o), 64'd0);
    $display("gating: kill and rdy2 low block ALU issue");
    valid_i = 1'b0;

`ifdef EXE_MULDIV_EN
    md_vec("mul_dir", 2'd1, 64'h1_0000_0000, 64'h1_0000_0003, 64'h3_0000_0000, 2);
    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      e = a * b;
      md_vec("mul_rand", 2'd1, a, b, e, 2);
    end
    md_vec("div_neg7_2", 2'd2, -64'sd7, 64'd2, -64'sd3, 65);
    md_vec("div_by_zero", 2'd2, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    md_vec("div_ovf", 2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 65);
    md_vec("div_100_7", 2'd2, 64'd100, 64'd7, 64'd14, 65);

    // Kill a divide on its 10th cycle
    drive(2'd2, 1'b0, 1'b0, 64'd0, 64'd0, 64'd100, 64'd7, 64'd0);
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("kill_div_busy", 64'(stall_o), 64'd1);
    kill_i = 1'b1;
    #1 chk("kill_div_valid", 64'(mul_div_valid_o), 64'd0);
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    chk("kill_stall_drop", 64'(stall_o), 64'd0);
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (mul_div_valid_o) cnt++;
    end
    chk("kill_no_result", 64'(cnt), 64'd0);
    $display("kill: divide dropped on cycle 10");
    md_vec("div_after_kill", 2'd2, 64'd9, -64'sd2, -64'sd4, 65);

    // Reset while a multiply result is on the channel
    drive(2'd1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd3, 64'd5, 64'd0);
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk("rstmul_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    chk("rstmul_result", mul_div_result_o, 64'd15);
    rst = 1'b1;
    #1;
    chk("rstmul_valid0", 64'(mul_div_valid_o), 64'd0);
    chk("rstmul_result0", mul_div_result_o, 64'd0);
    chk("rstmul_stall0", 64'(stall_o), 64'd0);
    $display("reset mid-mul: outputs cleared");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmul_idle", 64'(stall_o), 64'd0);
`else
    // Without mul/div units: issue of unit 1/2 flags illegal, nothing else moves
    for (int u = 1; u <= 2; u++) begin
      drive(2'(u), 1'b0, 1'b0, 64'd0, 64'd0, 64'd6, 64'd7, 64'd0);
      chk("illegal_flag", 64'(illegal_o), 64'd1);
      chk("illegal_no_arith", 64'(arith_valid_o), 64'd0);
      rdy1_i = 1'b0;
      #1 chk("illegal_needs_rdy", 64'(illegal_o), 64'd0);
      rdy1_i = 1'b1;
      kill_i = 1'b1;
      #1 chk("illegal_killed", 64'(illegal_o), 64'd0);
      kill_i = 1'b0;
      $display("unit %0d issued without mul/div: illegal flagged", u);
      @(posedge clk);
      #1 valid_i = 1'b0;
      cnt = 0;
      repeat (4) begin
        @(negedge clk);
        if (stall_o || mul_div_valid_o || illegal_o) cnt++;
      end
      chk("illegal_quiet", 64'(cnt), 64'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
